// File: rtl/fifo_cmd_ctrl_pkg.sv
// fifo_cmd_ctrl_pkg
//   Shared definitions for the fifo command stage:
//   - fifo opcode encodings driven on the opcode bus
//   - controller FSM state encoding
package fifo_cmd_ctrl_pkg;

    typedef logic [1:0] opcode_t;

    localparam opcode_t OP_NOP   = 2'b00;
    localparam opcode_t OP_READ  = 2'b01;
    localparam opcode_t OP_WRITE = 2'b10;
    localparam opcode_t OP_RESET = 2'b11;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

endpackage

// File: rtl/fifo_cmd_ctrl_if.sv
// fifo_cmd_ctrl_if
//   Opcode bus between the command stage (master) and the opcode-driven fifo (slave).
//   fifo_opcode    master -> slave   one operation per cycle
//   fifo_data      master -> slave   write word
//   fifo_dout      slave  -> master  read word
//   fifo_overflow  slave  -> master  fifo error flag
//   fifo_underflow slave  -> master  fifo error flag
interface fifo_cmd_ctrl_if
    import fifo_cmd_ctrl_pkg::*;
#(
    parameter int data_width = 4
);
    opcode_t               fifo_opcode;
    logic [data_width-1:0] fifo_data;
    logic [data_width-1:0] fifo_dout;
    logic                  fifo_overflow;
    logic                  fifo_underflow;

    modport master (
        output fifo_opcode,
        output fifo_data,
        input  fifo_dout,
        input  fifo_overflow,
        input  fifo_underflow
    );

    modport slave (
        input  fifo_opcode,
        input  fifo_data,
        output fifo_dout,
        output fifo_overflow,
        output fifo_underflow
    );
endinterface

// File: rtl/fifo_cmd_ctrl_rr_arb.sv
// fifo_cmd_ctrl_rr_arb
//   Two-way round-robin between the write and read sides of the command stage.
//   req_wr/req_rd     requests from producer/consumer
//   avail_wr/avail_rd slot availability from the shadow count
//   last_rd           1 when the previous grant was a read (write gets priority next)
//   grant_wr/grant_rd at most one asserted
//   ready_wr/ready_rd each depends only on the opposite side's request
module fifo_cmd_ctrl_rr_arb (
    input  logic req_wr,
    input  logic req_rd,
    input  logic avail_wr,
    input  logic avail_rd,
    input  logic last_rd,
    output logic grant_wr,
    output logic grant_rd,
    output logic ready_wr,
    output logic ready_rd
);
    // A side loses its slot only when the other side is competing and holds the turn.
    assign ready_wr = avail_wr & ~(req_rd & avail_rd & ~last_rd);
    assign ready_rd = avail_rd & ~(req_wr & avail_wr & last_rd);

    assign grant_wr = req_wr & ready_wr;
    assign grant_rd = req_rd & ready_rd;
endmodule

// File: rtl/fifo_cmd_ctrl.sv
// fifo_cmd_ctrl
//   Upstream command stage for the opcode-driven fifo. Merges a valid/ready write stream and a
//   req/ready read stream onto the one-op-per-cycle opcode bus, tracks a shadow occupancy so the
//   fifo never overflows or underflows, qualifies fifo_dout with rd_valid and latches fifo errors.
//   clk, rst_n        clock, synchronous active-low reset
//   clear             synchronous flush request
//   wr_valid/wr_data/wr_ready   producer stream
//   rd_req/rd_ready             consumer request
//   rd_valid/rd_data            read word, valid two edges after its grant
//   count             shadow occupancy 0..num_elements
//   err               sticky error flag, cleared by clear or reset
//   fifo              opcode bus (master side)
//
//   state   | meaning
//   ST_INIT | opcode RESET on the bus for one cycle, no grants
//   ST_RUN  | normal arbitration of write/read requests
//   ST_ERR  | fifo flagged an error; bus idle until clear
module fifo_cmd_ctrl
    import fifo_cmd_ctrl_pkg::*;
#(
    parameter int data_width   = 4,
    parameter int num_elements = 4,
    parameter int index_width  = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   wr_valid,
    input  logic [data_width-1:0]  wr_data,
    output logic                   wr_ready,
    input  logic                   rd_req,
    output logic                   rd_ready,
    output logic                   rd_valid,
    output logic [data_width-1:0]  rd_data,
    output logic [index_width:0]   count,
    output logic                   err,
    fifo_cmd_ctrl_if.master        fifo
);
    localparam logic [index_width:0] FULL_COUNT = (index_width + 1)'(num_elements);

    state_t state;
    logic   last_rd;
    logic   can_wr;
    logic   can_rd;
    logic   grant_wr;
    logic   grant_rd;

    assign can_wr  = (state == ST_RUN) && (count < FULL_COUNT);
    assign can_rd  = (state == ST_RUN) && (count != '0);
    assign rd_data = fifo.fifo_dout;

    fifo_cmd_ctrl_rr_arb u_arb (
        .req_wr   (wr_valid),
        .req_rd   (rd_req),
        .avail_wr (can_wr),
        .avail_rd (can_rd),
        .last_rd  (last_rd),
        .grant_wr (grant_wr),
        .grant_rd (grant_rd),
        .ready_wr (wr_ready),
        .ready_rd (rd_ready)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= ST_INIT;
            fifo.fifo_opcode <= OP_RESET;
            fifo.fifo_data   <= '0;
            count            <= '0;
            rd_valid         <= 1'b0;
            err              <= 1'b0;
            last_rd          <= 1'b0;
        end else begin
            // A read already on the bus completes even if clear arrives now.
            rd_valid <= (fifo.fifo_opcode == OP_READ);
            if (clear) begin
                state            <= ST_INIT;
                fifo.fifo_opcode <= OP_RESET;
                count            <= '0;
                err              <= 1'b0;
            end else begin
                case (state)
                    ST_INIT: begin
                        state            <= ST_RUN;
                        fifo.fifo_opcode <= OP_NOP;
                    end
                    ST_RUN: begin
                        fifo.fifo_opcode <= OP_NOP;
                        if (grant_wr) begin
                            fifo.fifo_opcode <= OP_WRITE;
                            fifo.fifo_data   <= wr_data;
                            count            <= count + 1'b1;
                            last_rd          <= 1'b0;
                        end else if (grant_rd) begin
                            fifo.fifo_opcode <= OP_READ;
                            count            <= count - 1'b1;
                            last_rd          <= 1'b1;
                        end
                        // A handshake completed this edge is still honoured on the error edge.
                        if (fifo.fifo_overflow || fifo.fifo_underflow) begin
                            state <= ST_ERR;
                            err   <= 1'b1;
                        end
                    end
                    ST_ERR: begin
                        fifo.fifo_opcode <= OP_NOP;
                        err              <= 1'b1;
                    end
                    default: begin
                        state            <= ST_INIT;
                        fifo.fifo_opcode <= OP_RESET;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fifo_cmd_ctrl.sv
// tb_fifo_cmd_ctrl
//   Drives fifo_cmd_ctrl against a behavioural opcode fifo and compares every cycle with a
//   transaction-level reference: occupancy, turn-taking, error/clear flow and a data scoreboard.
module tb_fifo_cmd_ctrl;
    import fifo_cmd_ctrl_pkg::*;

    localparam int DW = 4;
    localparam int NE = 4;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst_n, clear, wr_valid, rd_req;
    logic [DW-1:0] wr_data;
    logic          wr_ready, rd_ready, rd_valid, err;
    logic [DW-1:0] rd_data;
    logic [IW:0]   count;

    fifo_cmd_ctrl_if #(.data_width(DW)) bus ();

    fifo_cmd_ctrl #(.data_width(DW), .num_elements(NE), .index_width(IW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .wr_valid (wr_valid),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .rd_req   (rd_req),
        .rd_ready (rd_ready),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .count    (count),
        .err      (err),
        .fifo     (bus)
    );

    always #5 clk = ~clk;

    // Behavioural opcode fifo
    logic [DW-1:0] mem_q[$];
    logic [DW-1:0] f_dout = '0;
    logic          f_ovf = 1'b0;
    logic          f_udf = 1'b0;
    logic          force_udf = 1'b0;

    always @(posedge clk) begin
        f_ovf <= 1'b0;
        f_udf <= 1'b0;
        case (bus.fifo_opcode)
            OP_RESET: mem_q.delete();
            OP_WRITE: if (mem_q.size() < NE) mem_q.push_back(bus.fifo_data); else f_ovf <= 1'b1;
            OP_READ:  if (mem_q.size() > 0) f_dout <= mem_q.pop_front(); else f_udf <= 1'b1;
            default: ;
        endcase
    end

    assign bus.fifo_dout      = f_dout;
    assign bus.fifo_overflow  = f_ovf;
    assign bus.fifo_underflow = f_udf | force_udf;

    // Reference model: 0 = initialising, 1 = running, 2 = error
    int            m_state = 0;
    int            m_count = 0;
    bit            m_last_rd = 1'b0;
    bit            m_err = 1'b0;
    int            m_op = 3;
    bit            m_rv = 1'b0;
    bit            m_gw, m_gr;
    int            edge_no = 0;
    int            rd_grant_edge = -10;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] pend_q[$];
    logic [DW-1:0] got_q[$];
    bit            obs_gw, obs_gr;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input int exp);
        n_checks++;
        if (obs === 32'(exp)) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    endtask

    task automatic cycle();
        bit cw, cr, rd_turn, gw, gr;
        logic [DW-1:0] w;
        @(negedge clk);
        cw      = (m_state == 1) && (m_count < NE);
        cr      = (m_state == 1) && (m_count > 0);
        rd_turn = !m_last_rd;
        gw = wr_valid && cw && !(rd_req && cr && rd_turn);
        gr = rd_req && cr && !(wr_valid && cw && !rd_turn);
        check("wr_ready", wr_ready, int'(cw && !(rd_req && cr && rd_turn)));
        check("rd_ready", rd_ready, int'(cr && !(wr_valid && cw && !rd_turn)));
        check("count", count, m_count);
        check("err", err, int'(m_err));
        check("opcode", bus.fifo_opcode, m_op);
        check("rd_valid", rd_valid, int'(m_rv));
        if (m_rv) begin
            if (pend_q.size() > 0) begin
                w = pend_q.pop_front();
                check("rd_data", rd_data, int'(w));
            end else begin
                check("rd_data_pending", 0, 1);
            end
        end
        if (rd_valid === 1'b1) got_q.push_back(rd_data);
        obs_gw = (wr_valid && wr_ready) === 1'b1;
        obs_gr = (rd_req && rd_ready) === 1'b1;
        check("one_grant", int'(obs_gw && obs_gr), 0);

        edge_no++;
        if (!rst_n) begin
            m_state = 0; m_count = 0; m_last_rd = 0; m_err = 0; m_op = 3; m_rv = 0;
            exp_q.delete(); pend_q.delete();
            gw = 0; gr = 0;
        end else begin
            m_rv = (rd_grant_edge == edge_no - 1);
            if (clear) begin
                m_state = 0; m_count = 0; m_err = 0; m_op = 3;
                exp_q.delete();
                gw = 0; gr = 0;
            end else if (m_state == 0) begin
                m_state = 1; m_op = 0;
            end else if (m_state == 2) begin
                m_op = 0;
            end else begin
                m_op = 0;
                if (gw) begin
                    m_count++; m_last_rd = 0; m_op = 2;
                    exp_q.push_back(wr_data);
                end
                if (gr) begin
                    m_count--; m_last_rd = 1; m_op = 1;
                    rd_grant_edge = edge_no;
                    if (exp_q.size() > 0) pend_q.push_back(exp_q.pop_front());
                end
                if (bus.fifo_overflow || bus.fifo_underflow) begin
                    m_state = 2; m_err = 1;
                end
            end
        end
        m_gw = gw;
        m_gr = gr;
        @(posedge clk);
        #1;
    endtask

    logic [DW-1:0] words[4];
    int nacc;

    initial begin
        words = '{4'hA, 4'hB, 4'hC, 4'hD};
        rst_n = 0; clear = 0; wr_valid = 0; rd_req = 0; wr_data = '0;

        // 1: reset, release, one INIT cycle
        repeat (3) cycle();
        check("t1_op_reset", bus.fifo_opcode, int'(OP_RESET));
        rst_n = 1;
        cycle();
        check("t1_op_nop", bus.fifo_opcode, int'(OP_NOP));
        check("t1_count", count, 0);

        // 2: fill with A..D, fifth write held
        nacc = 0;
        wr_valid = 1;
        for (int i = 0; i < 8; i++) begin
            wr_data = (nacc < 4) ? words[nacc] : 4'hE;
            cycle();
            if (m_gw) nacc++;
        end
        check("t2_count_full", count, 4);
        check("t2_wr_ready_full", wr_ready, 0);
        check("t2_no_overflow", bus.fifo_overflow, 0);
        check("t2_err", err, 0);

        // 3: drain
        wr_valid = 0;
        rd_req = 1;
        got_q.delete();
        repeat (8) cycle();
        check("t3_count_empty", count, 0);
        check("t3_rd_ready_empty", rd_ready, 0);
        check("t3_nreads", got_q.size(), 4);
        for (int i = 0; i < 4 && i < got_q.size(); i++) check("t3_order", got_q[i], int'(words[i]));

        // 4: contention from count=2
        rd_req = 0;
        wr_valid = 1;
        for (int i = 0; i < 10 && m_count < 2; i++) begin
            wr_data = 4'($urandom);
            cycle();
        end
        check("t4_count_start", count, 2);
        rd_req = 1;
        for (int i = 0; i < 6; i++) begin
            wr_data = 4'($urandom);
            cycle();
            check("t4_rd_grant", int'(obs_gr), int'(i % 2 == 0));
            check("t4_wr_grant", int'(obs_gw), int'(i % 2 == 1));
            check("t4_count_range", int'(count >= 1 && count <= 2), 1);
        end

        // 5: forced underflow, then clear
        wr_valid = 0; rd_req = 0;
        repeat (3) cycle();
        force_udf = 1;
        cycle();
        force_udf = 0;
        check("t5_err", err, 1);
        wr_valid = 1; rd_req = 1;
        check("t5_wr_ready", wr_ready, 0);
        check("t5_rd_ready", rd_ready, 0);
        repeat (2) cycle();
        check("t5_err_sticky", err, 1);
        wr_valid = 0; rd_req = 0;
        clear = 1;
        cycle();
        clear = 0;
        check("t5_op_reset", bus.fifo_opcode, int'(OP_RESET));
        check("t5_count", count, 0);
        cycle();
        check("t5_err_clr", err, 0);
        check("t5_op_nop", bus.fifo_opcode, int'(OP_NOP));

        // 6: clear right after a write grant at count=3
        wr_valid = 1;
        for (int i = 0; i < 10 && m_count < 3; i++) begin
            wr_data = 4'($urandom);
            cycle();
        end
        check("t6_count3", count, 3);
        cycle();
        check("t6_op_write", bus.fifo_opcode, int'(OP_WRITE));
        wr_valid = 0; rd_req = 1; clear = 1;
        cycle();
        clear = 0;
        check("t6_op_reset", bus.fifo_opcode, int'(OP_RESET));
        check("t6_count", count, 0);
        check("t6_rd_ready_init", rd_ready, 0);
        cycle();
        check("t6_rd_ready_empty", rd_ready, 0);
        cycle();
        rd_req = 0;

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            rst_n     = ($urandom_range(0, 149) != 0);
            clear     = ($urandom_range(0, 49) == 0);
            force_udf = ($urandom_range(0, 99) == 0);
            wr_valid  = ($urandom_range(0, 2) != 0);
            rd_req    = ($urandom_range(0, 2) != 0);
            wr_data   = 4'($urandom);
            cycle();
        end
        rst_n = 1; clear = 0; force_udf = 0; wr_valid = 0; rd_req = 1;
        repeat (10) cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
